word_serializer_32: RTL and testbench

//   Drains 32-bit result words (registered convolution/accumulator outputs) and emits them as a byte

---
 rtl/conv_pkg.sv | 9 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/word_serializer_32.sv | 65 ++++++
 tb/tb_word_serializer_32.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, word/byte types and serializer states
package conv_pkg;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef enum logic {IDLE, SEND} ser_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with occupancy count
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == ($clog2(DEPTH+1))'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    // storage is not reset; only valid entries are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/word_serializer_32.sv
// word_serializer_32: buffers result words and streams them out LSB byte first
module word_serializer_32
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  word_t                      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output byte_t                      out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);
    localparam int KW = $clog2(BYTES_PER_WORD);
    localparam logic [KW-1:0] KLAST = KW'(BYTES_PER_WORD - 1);
    ser_state_e state, state_nxt;
    logic [KW-1:0] k;
    word_t sr, head;
    logic full, empty, push, pop, fire, at_last;
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign at_last   = k == KLAST;
    assign pop       = !empty && (state == IDLE || (fire && at_last));
    assign out_valid = state == SEND;
    assign out_data  = sr[BYTE_W-1:0];
    assign out_last  = at_last && out_valid;
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    // reload keeps us in SEND back to back; going idle only when the last byte leaves with nothing queued
    always_comb begin
        state_nxt = pop ? SEND : (fire && at_last) ? IDLE : state;
    end
    // shift register and byte index; the low byte of sr is the presented output byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
            k  <= '0;
        end else if (pop) begin
            sr <= head;
            k  <= '0;
        end else if (fire) begin
            sr <= sr >> BYTE_W;
            k  <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_word_serializer_32.sv
// tb_word_serializer_32: randomized scoreboard bench for the word serializer
module tb_word_serializer_32;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_data;
    logic [2:0]  fill_level;
    int total = 0, bad = 0, acc_cnt = 0, cyc;
    bit rand_or = 0, hold = 0;
    logic [7:0] hold_data;
    logic hold_last;
    logic [8:0] expq[$];
    logic [8:0] e;

    word_serializer_32 #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: an accepted word becomes four bytes, low byte first, last flag on the fourth
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            acc_cnt++;
            for (int i = 0; i < 4; i++) expq.push_back({i == 3, in_data[8*i +: 8]});
        end
    end

    // monitor: compare each transferred byte and check stability while stalled
    always @(negedge clk) begin
        if (rst) hold = 0;
        else begin
            if (hold) begin
                chk("stable_valid", {31'b0, out_valid}, 1);
                chk("stable_data", {24'b0, out_data}, {24'b0, hold_data});
                chk("stable_last", {31'b0, out_last}, {31'b0, hold_last});
            end
            hold = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("unexpected_byte", {24'b0, out_data}, 32'hxx);
                else begin
                    e = expq.pop_front();
                    chk("byte", {24'b0, out_data}, {24'b0, e[7:0]});
                    chk("last", {31'b0, out_last}, {31'b0, e[8]});
                end
            end
        end
    end

    always @(posedge clk) if (rand_or) #1 out_ready = 1'($urandom % 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        int t;
        n = acc_cnt;
        in_valid = 1;
        in_data = w;
        t = 0;
        while (acc_cnt == n && t < 200) begin
            step();
            t++;
        end
        in_valid = 0;
        if (acc_cnt == n) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || out_valid) && t < 500) begin
            step();
            t++;
        end
        chk("drain", {31'b0, (expq.size() == 0 && !out_valid)}, 1);
    endtask

    initial begin
        #3;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_fill", {29'b0, fill_level}, 0);
        chk("rst_ready", {31'b0, in_ready}, 1);
        chk("rst_data", {24'b0, out_data}, 0);
        chk("rst_last", {31'b0, out_last}, 0);
        step();
        rst = 0;
        step();
        // single word, latency and order
        out_ready = 1;
        in_valid = 1;
        in_data = 32'hDDCCBBAA;
        step();
        in_valid = 0;
        chk("lat_e_valid", {31'b0, out_valid}, 0);
        chk("lat_e_fill", {29'b0, fill_level}, 1);
        step();
        chk("lat_e1_valid", {31'b0, out_valid}, 1);
        chk("lat_e1_data", {24'b0, out_data}, 32'hAA);
        chk("lat_e1_fill", {29'b0, fill_level}, 0);
        repeat (3) step();
        chk("t1_dd", {24'b0, out_data}, 32'hDD);
        chk("t1_dd_last", {31'b0, out_last}, 1);
        wait_drain();
        // back-to-back pushes into a stalled output; the sixth is refused
        out_ready = 0;
        cyc = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1;
            in_data = $urandom;
            step();
        end
        in_valid = 0;
        chk("t2_accepted", acc_cnt - cyc, 5);
        chk("t2_fill", {29'b0, fill_level}, 4);
        chk("t2_ready", {31'b0, in_ready}, 0);
        out_ready = 1;
        cyc = 0;
        while (expq.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t2_no_gap_cycles", cyc, 20);
        wait_drain();
        // random backpressure over eight words
        rand_or = 1;
        for (int i = 0; i < 8; i++) begin
            push_word($urandom);
            if ($urandom % 2) step();
        end
        wait_drain();
        rand_or = 0;
        step();
        // simultaneous push and final-byte pop at fill level 3
        out_ready = 0;
        for (int i = 0; i < 4; i++) push_word($urandom);
        step();
        chk("t4_fill_pre", {29'b0, fill_level}, 3);
        out_ready = 1;
        cyc = 0;
        while (!(out_last && fill_level == 3) && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t4_reach_last", {31'b0, out_last}, 1);
        in_valid = 1;
        in_data = 32'h5A5AA5A5;
        step();
        in_valid = 0;
        chk("t4_fill", {29'b0, fill_level}, 3);
        chk("t4_valid", {31'b0, out_valid}, 1);
        chk("t4_not_last", {31'b0, out_last}, 0);
        wait_drain();
        // asynchronous reset in the middle of a word
        out_ready = 1;
        in_valid = 1;
        in_data = 32'h44332211;
        step();
        in_data = 32'h01020304;
        step();
        in_data = 32'h0A0B0C0D;
        step();
        in_valid = 0;
        cyc = 0;
        while (!(out_valid && out_data == 8'h33) && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t5_at_33", {24'b0, out_data}, 32'h33);
        #2;
        rst = 1;
        expq.delete();
        #1;
        chk("t5_valid", {31'b0, out_valid}, 0);
        chk("t5_fill", {29'b0, fill_level}, 0);
        chk("t5_data", {24'b0, out_data}, 0);
        chk("t5_ready", {31'b0, in_ready}, 1);
        step();
        rst = 0;
        step();
        push_word(32'h000000FF);
        wait_drain();
        // pushes while full must be ignored
        out_ready = 0;
        for (int i = 0; i < 5; i++) push_word($urandom);
        step();
        chk("t6_fill_full", {29'b0, fill_level}, 4);
        cyc = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom % 2);
            in_data = $urandom;
            step();
            chk("t6_fill_hold", {29'b0, fill_level}, 4);
        end
        in_valid = 0;
        chk("t6_no_accept", acc_cnt - cyc, 0);
        out_ready = 1;
        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
